imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction-memory interface: receives a framed little-endian byte stream over a valid/ready handshake, packs it into 32-bit words and writes them sequentially into instruction memory from byte address 0.
- Holds the core (PC register, register file) via cpu_hold until the image is fully written.
- Sits beside the processor top level, driving the memory write port while the core's PC drives the read port.

Parameters:
- DATA_WIDTH, 32, instruction word width; must be 32 (4 bytes per word).
- ADDR_WIDTH, 8, instruction-memory word-address bits; capacity = 2**ADDR_WIDTH words.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- rx_data  input  8  stream byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  loader can accept a byte; a byte transfers on a clk edge where rx_valid && rx_ready.
- imem_we  output  1  instruction-memory write enable, one cycle per word.
- imem_addr  output  DATA_WIDTH  byte address of the write, word-aligned (word_idx*4).
- imem_wd  output  DATA_WIDTH  write data.
- cpu_hold  output  1  core must stay in reset/stall while high.
- busy  output  1  load in progress.
- done  output  1  image loaded successfully.
- err  output  1  frame rejected.

Behaviour:
- Frame format: 2 length bytes (N = word count, 16-bit, low byte first), then 4*N data bytes. Each word is assembled little-endian: the first byte goes to [7:0], the fourth to [31:24].
- States:
  - IDLE: start -> LEN_LO.
  - LEN_LO: on byte accept -> LEN_HI.
  - LEN_HI: on byte accept, N is decoded. N==0 -> DONE. N > 2**ADDR_WIDTH -> ERR. Otherwise -> DATA.
  - DATA: accept bytes, byte_cnt 0..3. The accept at byte_cnt==3 -> WRITE.
  - WRITE: one cycle. word_idx increments. Exit to DONE if the incremented word_idx == N, else DATA.
  - DONE, ERR: start -> LEN_LO.
- Output decode by state:
  - rx_ready = 1 in LEN_LO, LEN_HI, DATA; 0 in all other states. It depends on state only, never on rx_valid.
  - imem_we = 1 only in WRITE. imem_addr and imem_wd are held from the word register and the word_idx<<2 register, so they are stable for the whole WRITE cycle.
  - Latency: 4th byte accepted at edge k -> imem_we high in cycle k..k+1. The next byte can be accepted no earlier than the edge after WRITE, so the maximum rate is 4 bytes per 5 cycles.
  - busy = 1 in LEN_LO, LEN_HI, DATA, WRITE.
  - done = 1 in DONE only; err = 1 in ERR only.
  - cpu_hold = 0 only in DONE; 1 in every other state, including IDLE after reset and ERR.
- start received while busy is ignored. A new start from DONE/ERR resets word_idx, byte_cnt and N, reasserts cpu_hold, and rewrites from address 0.
- Arithmetic and widths:
  - word_idx is ADDR_WIDTH+1 bits, so N == 2**ADDR_WIDTH (full memory) is legal; the last write goes to byte address (2**ADDR_WIDTH-1)*4.
  - imem_addr upper bits are zero-extended.
- Reset (rst low, asynchronous, any state including mid-word or WRITE):
  - state=IDLE; byte_cnt, word_idx, N and the word register are 0.
  - imem_we=0, imem_addr=0, imem_wd=0, rx_ready=0, busy=0, done=0, err=0, cpu_hold=1.
  - A partial word is discarded and never written.
- Bytes presented while rx_ready=0 are not consumed; the source holds them.

Decomposition:
- Shared package (imem_loader_pkg): state encoding constants (IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR), BYTES_PER_WORD=4, LEN_BYTES=2, LEN_WIDTH=16.
- One sub-module: byte_word_packer. It contains the 2-bit byte counter and 32-bit little-endian shift/insert register, with inputs byte_in, byte_en and clear, and outputs word and word_full. The FSM, length register and address counter stay in imem_loader.

Test Plan:
- Reset, then start; stream 02 00 13 00 50 00 93 00 A0 00 -> two imem_we pulses: addr 0x0/wd 0x00500013, then addr 0x4/wd 0x00A00093. After the second pulse: done=1, cpu_hold=0, busy=0.
- rx_valid toggling 1/0 every cycle during the same frame -> identical writes and data. rx_ready is 0 in each WRITE cycle, and no byte is lost or duplicated.
- Length bytes 00 00 -> DONE immediately after LEN_HI, zero imem_we pulses, cpu_hold=0.
- ADDR_WIDTH=8, N=257 (01 01) -> err=1, cpu_hold=1, no imem_we. N=256 -> 256 writes, last addr 0x3FC, done=1.
- rst low after 6 data bytes (1.5 words) -> all outputs at reset values, only word 0 was written. A fresh start plus a full frame rewrites from addr 0.
- start pulsed mid-DATA -> ignored, load completes normally. start in DONE -> cpu_hold=1 next cycle and the second image overwrites from 0x0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared FSM state encodings and frame-format constants for the instruction-memory loader.
package imem_loader_pkg;
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LEN_LO = 3'd1;
  localparam logic [2:0] LEN_HI = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] WRITE  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
  localparam logic [2:0] ERR    = 3'd6;
  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES      = 2;
  localparam int LEN_WIDTH      = 16;
endpackage

// File: rtl/imem_loader_packer.sv
// byte_word_packer: assembles four stream bytes little-endian into a 32-bit word.
// Ports: clk/rst (async active-low), byte_in/byte_en (byte to insert), clear (restart word),
//        word (assembled word), word_full (the byte being inserted completes the word).
module byte_word_packer import imem_loader_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_en,
  input  logic        clear,
  output logic [31:0] word,
  output logic        word_full
);
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  // Shifting in from the top leaves the first byte in [7:0] after four inserts.
  always_comb begin
    cnt_d  = clear ? 2'd0 : byte_en ? cnt_q + 2'd1 : cnt_q;
    word_d = clear ? '0 : byte_en ? {byte_in, word_q[31:8]} : word_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end
  assign word      = word_q;
  assign word_full = byte_en && cnt_q == 2'(BYTES_PER_WORD - 1);
endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed byte stream and writes it word by word into instruction memory.
// Ports: clk/rst (async active-low), start (begin a load), rx_data/rx_valid/rx_ready (byte handshake),
//        imem_we/imem_addr/imem_wd (memory write port), cpu_hold (core held while high),
//        busy/done/err (load status).
module imem_loader import imem_loader_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [DATA_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wd,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam logic [LEN_WIDTH-1:0] MAX_N = LEN_WIDTH'(2 ** ADDR_WIDTH);
  logic [2:0]            state_q, state_d;
  logic [LEN_WIDTH-1:0]  n_q, n_d, n_full;
  logic [ADDR_WIDTH:0]   idx_q, idx_d, idx_inc;
  logic                  acc, clear, word_full;
  logic [31:0]           word;
  assign acc     = rx_valid && rx_ready;
  assign n_full  = {rx_data, n_q[7:0]};
  assign idx_inc = idx_q + 1'b1;
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    clear   = 1'b0;
    case (state_q)
      IDLE, DONE, ERR: if (start) begin
        state_d = LEN_LO;
        n_d     = '0;
        idx_d   = '0;
        clear   = 1'b1;
      end
      LEN_LO: if (acc) begin
        state_d = LEN_HI;
        n_d     = {8'h00, rx_data};
      end
      LEN_HI: if (acc) begin
        n_d     = n_full;
        state_d = n_full == '0 ? DONE : n_full > MAX_N ? ERR : DATA;
      end
      DATA: if (acc && word_full) state_d = WRITE;
      WRITE: begin
        idx_d   = idx_inc;
        state_d = LEN_WIDTH'(idx_inc) == n_q ? DONE : DATA;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
    end
  end
  byte_word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .byte_in   (rx_data),
    .byte_en   (acc && state_q == DATA),
    .clear     (clear),
    .word      (word),
    .word_full (word_full)
  );
  // Address and data come straight from registers, so they are stable through WRITE.
  assign rx_ready  = state_q == LEN_LO || state_q == LEN_HI || state_q == DATA;
  assign imem_we   = state_q == WRITE;
  assign imem_addr = DATA_WIDTH'({idx_q, 2'b00});
  assign imem_wd   = DATA_WIDTH'(word);
  assign busy      = rx_ready || imem_we;
  assign done      = state_q == DONE;
  assign err       = state_q == ERR;
  assign cpu_hold  = state_q != DONE;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frames against a queue-based write model of the loader.
module tb_imem_loader;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready, imem_we, cpu_hold, busy, done, err;
  logic [31:0] imem_addr, imem_wd;
  int          n_cmp = 0, n_err = 0, base;
  logic [7:0]  fr[$];
  logic [31:0] exp_addr[$], exp_wd[$], log_addr[$], log_wd[$];
  logic [255:0] f1 = 256'h02_00_13_00_50_00_93_00_A0_00;

  always #5 clk = ~clk;

  imem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wd(imem_wd),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Every write must match the next word the model derived from the frames sent.
  always @(negedge clk) if (rst) begin
    chk("hold_vs_done", 32'(cpu_hold), 32'(!done));
    if (imem_we) begin
      chk("ready_in_write", 32'(rx_ready), 32'd0);
      log_addr.push_back(imem_addr);
      log_wd.push_back(imem_wd);
      if (exp_addr.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got addr %h wd %h expected no write", imem_addr, imem_wd);
      end else begin
        chk("write_addr", imem_addr, exp_addr.pop_front());
        chk("write_wd", imem_wd, exp_wd.pop_front());
      end
    end
  end

  task automatic load(input logic [255:0] v, input int nb);
    fr.delete();
    for (int i = 0; i < nb; i++) fr.push_back(v[8*(nb-1-i) +: 8]);
  endtask

  // Model: N from the header, then one write per complete word actually sent, up to N.
  task automatic expect_frame();
    int n, words;
    n = int'(fr[0]) | (int'(fr[1]) << 8);
    if (n <= 256) begin
      words = (fr.size() - 2) / 4;
      if (words > n) words = n;
      for (int i = 0; i < words; i++) begin
        exp_addr.push_back(32'(i * 4));
        exp_wd.push_back({fr[2+4*i+3], fr[2+4*i+2], fr[2+4*i+1], fr[2+4*i]});
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!rx_ready && t < 200);
    chk("byte_accept", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi, input bit tog);
    for (int i = lo; i < hi; i++) begin
      send_byte(fr[i]);
      if (tog) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_end(input bit want_err, input string nm);
    int t = 0;
    while ((want_err ? err : done) !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk(nm, 32'(want_err ? err : done), 32'd1);
  endtask

  task automatic check_reset_vals();
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_wd", imem_wd, 32'd0);
    chk("rst_ready", 32'(rx_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 check_reset_vals();
    @(negedge clk) rst = 1'b1;
    // two-word frame, back-to-back bytes
    base = log_addr.size();
    load(f1, 10);
    expect_frame();
    pulse_start();
    send_range(0, 10, 1'b0);
    wait_end(1'b0, "t1_done");
    chk("t1_hold", 32'(cpu_hold), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_count", 32'(log_addr.size() - base), 32'd2);
    chk("t1_addr0", log_addr[base], 32'h0);
    chk("t1_wd0", log_wd[base], 32'h00500013);
    chk("t1_addr1", log_addr[base+1], 32'h4);
    chk("t1_wd1", log_wd[base+1], 32'h00A00093);
    // same frame with rx_valid toggling
    base = log_addr.size();
    expect_frame();
    pulse_start();
    send_range(0, 10, 1'b1);
    wait_end(1'b0, "t2_done");
    chk("t2_count", 32'(log_addr.size() - base), 32'd2);
    chk("t2_wd0", log_wd[base], 32'h00500013);
    chk("t2_wd1", log_wd[base+1], 32'h00A00093);
    // zero-length image
    base = log_addr.size();
    load(256'h00_00, 2);
    expect_frame();
    pulse_start();
    send_range(0, 2, 1'b0);
    wait_end(1'b0, "t3_done");
    chk("t3_hold", 32'(cpu_hold), 32'd0);
    chk("t3_count", 32'(log_addr.size() - base), 32'd0);
    // N = 257 exceeds capacity
    base = log_addr.size();
    load(256'h01_01, 2);
    expect_frame();
    pulse_start();
    send_range(0, 2, 1'b0);
    wait_end(1'b1, "t4_err");
    chk("t4_hold", 32'(cpu_hold), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("t4_count", 32'(log_addr.size() - base), 32'd0);
    // N = 256 fills memory
    base = log_addr.size();
    fr.delete();
    fr.push_back(8'h00);
    fr.push_back(8'h01);
    for (int i = 0; i < 256; i++)
      for (int j = 0; j < 4; j++) fr.push_back(8'(i + 64 * j));
    expect_frame();
    pulse_start();
    send_range(0, fr.size(), 1'b0);
    wait_end(1'b0, "t5_done");
    chk("t5_count", 32'(log_addr.size() - base), 32'd256);
    chk("t5_wd_first", log_wd[base], 32'hC0804000);
    chk("t5_addr_last", log_addr[base+255], 32'h3FC);
    chk("t5_wd_last", log_wd[base+255], 32'hBF7F3FFF);
    // reset after 1.5 words, then a fresh full load
    base = log_addr.size();
    load(f1 >> 16, 8);
    expect_frame();
    pulse_start();
    send_range(0, 8, 1'b0);
    rst = 1'b0;
    #1 check_reset_vals();
    chk("t6_count", 32'(log_addr.size() - base), 32'd1);
    chk("t6_wd0", log_wd[base], 32'h00500013);
    @(negedge clk) rst = 1'b1;
    load(f1, 10);
    expect_frame();
    pulse_start();
    send_range(0, 10, 1'b0);
    wait_end(1'b0, "t6_done");
    chk("t6_addr_re", log_addr[base+1], 32'h0);
    chk("t6_count2", 32'(log_addr.size() - base), 32'd3);
    // start mid-DATA is ignored
    base = log_addr.size();
    expect_frame();
    pulse_start();
    send_range(0, 4, 1'b0);
    pulse_start();
    send_range(4, 10, 1'b0);
    wait_end(1'b0, "t7_done");
    chk("t7_count", 32'(log_addr.size() - base), 32'd2);
    chk("t7_wd1", log_wd[base+1], 32'h00A00093);
    // start from DONE reloads from address 0
    base = log_addr.size();
    pulse_start();
    chk("t8_hold", 32'(cpu_hold), 32'd1);
    chk("t8_done", 32'(done), 32'd0);
    chk("t8_busy", 32'(busy), 32'd1);
    load(256'h01_00_EF_BE_AD_DE, 6);
    expect_frame();
    send_range(0, 6, 1'b0);
    wait_end(1'b0, "t8_end");
    chk("t8_addr", log_addr[base], 32'h0);
    chk("t8_wd", log_wd[base], 32'hDEADBEEF);
    chk("exp_drained", 32'(exp_addr.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
